rx_uart: RTL and testbench
==========================

# rx_uart

Serial UART receiver that pairs with the team's UART transmitter. It recovers start + data (+ parity) + stop frames, LSB first, from an asynchronous serial line by oversampling. It presents each received word as a one-cycle valid pulse with framing and parity status. It sits between the board RX pin and the data sink, and shares the baud-tick generator with the transmitter.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame.
- `OVERSAMPLE`, default 16: `sample_tick` pulses per bit period. Must be an even value ≥ 4.
- `clk`  in  1  system clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sample_tick`  in  1  one-`clk` strobe at OVERSAMPLE × baud rate.
- `serial_in`  in  1  asynchronous serial line; idles high.
- `o_data`  out  DATA_WIDTH  last received word; LSB was received first.
- `o_valid`  out  1  one-cycle pulse when a frame completes.
- `o_frame_err`  out  1  stop bit was sampled low; valid only while `o_valid` is high.
- `o_parity_err`  out  1  parity mismatch; valid only while `o_valid` is high.
- `o_busy`  out  1  high from start-bit detection until the receiver returns to IDLE.

## Operation
- `serial_in` passes through a 2-flop synchronizer. Both flops reset to 1. All decisions use the synchronized value `rx_s`.
- A tick counter `tcnt` (width clog2(OVERSAMPLE)) and a bit counter `bcnt` (width clog2(DATA_WIDTH)) advance only on `sample_tick`.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: wait for `rx_s`==0, then clear `tcnt` and go to START. `o_busy` is 0 only in IDLE.
- START: on the tick where `tcnt` reaches OVERSAMPLE/2−1 (mid start bit):
  - if `rx_s`==0, clear `tcnt` and `bcnt` and go to DATA;
  - otherwise treat it as a glitch and return to IDLE with no output.
- DATA: on each tick where `tcnt`==OVERSAMPLE−1 (mid-bit), shift `rx_s` into the MSB of the shift register (right shift) and wrap `tcnt` to 0. After DATA_WIDTH bits, go to PARITY if it is compiled in, otherwise to STOP.
- PARITY: sample one bit at mid-bit, then go to STOP.
- STOP: sample at mid-bit.
  - Copy the shift register to `o_data` and pulse `o_valid` for exactly one `clk`.
  - Set `o_frame_err` = ~`rx_s` for that same pulse.
  - If the stop sample is 1, go to IDLE; otherwise go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s`==1, then go to IDLE. This covers break and line-low conditions, so a held-low line yields exactly one frame-error pulse.
- `o_data` holds its value between pulses. `o_frame_err` and `o_parity_err` are 0 whenever `o_valid` is 0.
- The receiver has no backpressure. The sink must consume `o_data` before the next `o_valid`.

## Timing
- Reset values: `o_data`=0, `o_valid`=0, `o_frame_err`=0, `o_parity_err`=0, `o_busy`=0, FSM in IDLE, synchronizer flops = 1.
- Line-to-FSM latency: 2 `clk`. `o_busy` rises 1 `clk` after `rx_s` falls.
- `o_valid` is registered. It is high during the `clk` after the mid-stop `sample_tick`.
- The FSM reaches IDLE at mid-stop. A start bit arriving in the second half of the stop bit is detected normally, so back-to-back frames are supported.
- `reset` asserted mid-frame aborts the frame immediately with no `o_valid` pulse. All outputs take their reset values on the next `clk`.
- If `sample_tick` is held low, the FSM freezes in its current state.

## Configuration
- `RX_UART_PARITY_EN` defined:
  - the frame carries one parity bit after the data bits;
  - even parity applies: XOR of the data bits and the parity bit must be 0;
  - `o_parity_err` = 1 together with `o_valid` on a mismatch.
- Undefined:
  - no PARITY state; the frame is start + DATA_WIDTH + stop;
  - `o_parity_err` is tied to 0.

## Test plan
- Baud frame 0xA5 (OVERSAMPLE=16, 1 tick every 4 `clk`) -> exactly one `o_valid`, `o_data`=0xA5, `o_frame_err`=0, `o_busy` low afterwards.
- Low glitch of 4 ticks on an idle line -> no `o_valid`; `o_busy` pulses, then returns to 0 by tick 8.
- Frame 0x3C with stop bit forced low, then line held low for 3 bit times -> one `o_valid` with `o_frame_err`=1, `o_data`=0x3C; no further pulse until the line goes high and a new start bit is sent.
- With `RX_UART_PARITY_EN`: 0x01 with parity bit 1 -> `o_parity_err`=0; 0x01 with parity bit 0 -> `o_parity_err`=1.
- Back-to-back frames 0x00 then 0xFF with no idle gap -> two `o_valid` pulses, `o_data` 0x00 then 0xFF, no errors.
- `reset` asserted at data bit 4 of 0x5A, then frame 0x81 sent -> no pulse for 0x5A; `o_data`=0x81 with a single `o_valid`.

Source files
------------

// File: rtl/rx_uart_if.sv
// Receive-side output bundle of rx_uart: received word plus status strobes.
// master drives (the receiver), slave observes (the data sink).
interface rx_uart_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] o_data;
   logic                  o_valid;
   logic                  o_frame_err;
   logic                  o_parity_err;
   logic                  o_busy;

   modport master (
      output o_data,
      output o_valid,
      output o_frame_err,
      output o_parity_err,
      output o_busy
   );

   modport slave (
      input o_data,
      input o_valid,
      input o_frame_err,
      input o_parity_err,
      input o_busy
   );
endinterface

// File: rtl/rx_uart.sv
// Oversampling UART receiver: start + DATA_WIDTH data (LSB first) + optional parity + stop.
// Define RX_UART_PARITY_EN to add an even-parity bit after the data bits.
module rx_uart #(
   parameter int DATA_WIDTH = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      sample_tick,
   input  logic      serial_in,
   rx_uart_if.master rx
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [2:0] StIdle     = 3'd0;
   localparam logic [2:0] StStart    = 3'd1;
   localparam logic [2:0] StData     = 3'd2;
`ifdef RX_UART_PARITY_EN
   localparam logic [2:0] StParity   = 3'd3;
`endif
   localparam logic [2:0] StStop     = 3'd4;
   localparam logic [2:0] StWaitHigh = 3'd5;

   localparam logic [TW-1:0] MidStart = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] MidBit   = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LastBit  = BW'(DATA_WIDTH - 1);

   logic                  rx_meta, rx_s;
   logic [2:0]            state_q, state_d;
   logic [TW-1:0]         tcnt_q, tcnt_d;
   logic [BW-1:0]         bcnt_q, bcnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  ferr_q, ferr_d;
`ifdef RX_UART_PARITY_EN
   logic                  par_q, par_d;
   logic                  perr_q, perr_d;
`endif

   // Synchronizer resets to the idle (high) line level to avoid a false start.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= serial_in;
         rx_s    <= rx_meta;
      end
   end

   always_comb begin
      state_d = state_q;
      tcnt_d  = tcnt_q;
      bcnt_d  = bcnt_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
`ifdef RX_UART_PARITY_EN
      par_d   = par_q;
      perr_d  = 1'b0;
`endif
      case (state_q)
         StIdle: begin
            if (!rx_s) begin
               tcnt_d  = '0;
               state_d = StStart;
            end
         end
         StStart: begin
            if (sample_tick) begin
               if (tcnt_q == MidStart) begin
                  tcnt_d  = '0;
                  bcnt_d  = '0;
                  state_d = rx_s ? StIdle : StData;
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
         end
         StData: begin
            if (sample_tick) begin
               if (tcnt_q == MidBit) begin
                  tcnt_d                  = '0;
                  shift_d                 = shift_q >> 1;
                  shift_d[DATA_WIDTH-1]   = rx_s;
                  if (bcnt_q == LastBit) begin
`ifdef RX_UART_PARITY_EN
                     state_d = StParity;
`else
                     state_d = StStop;
`endif
                  end else begin
                     bcnt_d = bcnt_q + 1'b1;
                  end
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
         end
`ifdef RX_UART_PARITY_EN
         StParity: begin
            if (sample_tick) begin
               if (tcnt_q == MidBit) begin
                  tcnt_d  = '0;
                  par_d   = rx_s;
                  state_d = StStop;
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
         end
`endif
         StStop: begin
            if (sample_tick) begin
               if (tcnt_q == MidBit) begin
                  tcnt_d  = '0;
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  ferr_d  = ~rx_s;
`ifdef RX_UART_PARITY_EN
                  perr_d  = ^{shift_q, par_q};
`endif
                  // Returning to idle at mid-stop lets a back-to-back start bit be seen.
                  state_d = rx_s ? StIdle : StWaitHigh;
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
         end
         StWaitHigh: begin
            if (sample_tick && rx_s) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         tcnt_q  <= '0;
         bcnt_q  <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef RX_UART_PARITY_EN
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         bcnt_q  <= bcnt_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
`ifdef RX_UART_PARITY_EN
         par_q   <= par_d;
         perr_q  <= perr_d;
`endif
      end
   end

   assign rx.o_data      = data_q;
   assign rx.o_valid     = valid_q;
   assign rx.o_frame_err = ferr_q;
   assign rx.o_busy      = (state_q != StIdle);
`ifdef RX_UART_PARITY_EN
   assign rx.o_parity_err = perr_q;
`else
   assign rx.o_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_rx_uart.sv
// Directed self-checking bench for rx_uart: 16x oversampling, one sample_tick every 4 clk.
module tb_rx_uart;
   localparam int BitClk = 64;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic serial_in = 1'b1;
   logic sample_tick;
   logic [1:0] tick_div = 2'd0;

   int n_assert = 0;
   int n_fail = 0;
   int stray = 0;
   logic [7:0] log_data[$];
   logic       log_fe[$];
   logic       log_pe[$];

   rx_uart_if #(.DATA_WIDTH(8)) bus ();

   rx_uart #(.DATA_WIDTH(8), .OVERSAMPLE(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .sample_tick(sample_tick),
      .serial_in  (serial_in),
      .rx         (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) tick_div <= tick_div + 2'd1;
   assign sample_tick = (tick_div == 2'd3);

   always @(negedge clk) begin
      if (bus.o_valid) begin
         log_data.push_back(bus.o_data);
         log_fe.push_back(bus.o_frame_err);
         log_pe.push_back(bus.o_parity_err);
      end else if (bus.o_frame_err || bus.o_parity_err) begin
         stray++;
      end
   end

   task automatic send_bit(input logic b);
      @(negedge clk);
      serial_in = b;
      repeat (BitClk - 1) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef RX_UART_PARITY_EN
      send_bit(par);
`endif
      send_bit(stop);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_assert++;
      if (bus.o_data !== 8'h00) begin
         n_fail++; $display("FAIL reset_data: got %h expected 00", bus.o_data);
      end
      n_assert++;
      if (bus.o_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.o_valid);
      end
      n_assert++;
      if (bus.o_frame_err !== 1'b0) begin
         n_fail++; $display("FAIL reset_ferr: got %b expected 0", bus.o_frame_err);
      end
      n_assert++;
      if (bus.o_parity_err !== 1'b0) begin
         n_fail++; $display("FAIL reset_perr: got %b expected 0", bus.o_parity_err);
      end
      n_assert++;
      if (bus.o_busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.o_busy);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_glitch;
      int base;
      base = log_data.size();
      @(negedge clk);
      serial_in = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      n_assert++;
      if (bus.o_busy !== 1'b0) begin
         n_fail++; $display("FAIL glitch_busy_early: got %b expected 0", bus.o_busy);
      end
      @(posedge clk); #1;
      n_assert++;
      if (bus.o_busy !== 1'b1) begin
         n_fail++; $display("FAIL glitch_busy_rise: got %b expected 1", bus.o_busy);
      end
      repeat (14) @(negedge clk);
      serial_in = 1'b1;
      repeat (BitClk) @(negedge clk);
      n_assert++;
      if (bus.o_busy !== 1'b0) begin
         n_fail++; $display("FAIL glitch_busy_end: got %b expected 0", bus.o_busy);
      end
      n_assert++;
      if (log_data.size() !== base) begin
         n_fail++; $display("FAIL glitch_valid: got %0d pulses expected 0", log_data.size() - base);
      end
   endtask

   task automatic test_frame;
      int base;
      base = log_data.size();
      send_frame(8'hA5, ^8'hA5, 1'b1);
      repeat (8) @(negedge clk);
      n_assert++;
      if (log_data.size() !== base + 1) begin
         n_fail++; $display("FAIL frame_count: got %0d pulses expected 1", log_data.size() - base);
      end else begin
         n_assert++;
         if (log_data[base] !== 8'hA5) begin
            n_fail++; $display("FAIL frame_data: got %h expected a5", log_data[base]);
         end
         n_assert++;
         if (log_fe[base] !== 1'b0) begin
            n_fail++; $display("FAIL frame_ferr: got %b expected 0", log_fe[base]);
         end
         n_assert++;
         if (log_pe[base] !== 1'b0) begin
            n_fail++; $display("FAIL frame_perr: got %b expected 0", log_pe[base]);
         end
      end
      n_assert++;
      if (bus.o_busy !== 1'b0) begin
         n_fail++; $display("FAIL frame_busy: got %b expected 0", bus.o_busy);
      end
      n_assert++;
      if (bus.o_data !== 8'hA5) begin
         n_fail++; $display("FAIL frame_hold: got %h expected a5", bus.o_data);
      end
   endtask

   task automatic test_frame_err;
      int base;
      base = log_data.size();
      send_frame(8'h3C, ^8'h3C, 1'b0);
      repeat (3 * BitClk) @(negedge clk);
      n_assert++;
      if (log_data.size() !== base + 1) begin
         n_fail++; $display("FAIL ferr_count: got %0d pulses expected 1", log_data.size() - base);
      end else begin
         n_assert++;
         if (log_data[base] !== 8'h3C) begin
            n_fail++; $display("FAIL ferr_data: got %h expected 3c", log_data[base]);
         end
         n_assert++;
         if (log_fe[base] !== 1'b1) begin
            n_fail++; $display("FAIL ferr_flag: got %b expected 1", log_fe[base]);
         end
      end
      serial_in = 1'b1;
      repeat (2 * BitClk) @(negedge clk);
      send_frame(8'h55, ^8'h55, 1'b1);
      repeat (8) @(negedge clk);
      n_assert++;
      if (log_data.size() !== base + 2) begin
         n_fail++; $display("FAIL ferr_recover_count: got %0d pulses expected 2", log_data.size() - base);
      end else begin
         n_assert++;
         if (log_data[base+1] !== 8'h55 || log_fe[base+1] !== 1'b0) begin
            n_fail++; $display("FAIL ferr_recover: got %h/%b expected 55/0", log_data[base+1], log_fe[base+1]);
         end
      end
   endtask

`ifdef RX_UART_PARITY_EN
   task automatic test_parity;
      int base;
      base = log_data.size();
      send_frame(8'h01, 1'b1, 1'b1);
      send_frame(8'h01, 1'b0, 1'b1);
      repeat (8) @(negedge clk);
      n_assert++;
      if (log_data.size() !== base + 2) begin
         n_fail++; $display("FAIL parity_count: got %0d pulses expected 2", log_data.size() - base);
      end else begin
         n_assert++;
         if (log_pe[base] !== 1'b0) begin
            n_fail++; $display("FAIL parity_good: got %b expected 0", log_pe[base]);
         end
         n_assert++;
         if (log_pe[base+1] !== 1'b1) begin
            n_fail++; $display("FAIL parity_bad: got %b expected 1", log_pe[base+1]);
         end
      end
   endtask
`endif

   task automatic test_back_to_back;
      int base;
      base = log_data.size();
      send_frame(8'h00, 1'b0, 1'b1);
      send_frame(8'hFF, 1'b0, 1'b1);
      repeat (8) @(negedge clk);
      n_assert++;
      if (log_data.size() !== base + 2) begin
         n_fail++; $display("FAIL b2b_count: got %0d pulses expected 2", log_data.size() - base);
      end else begin
         n_assert++;
         if (log_data[base] !== 8'h00 || log_fe[base] !== 1'b0 || log_pe[base] !== 1'b0) begin
            n_fail++; $display("FAIL b2b_first: got %h/%b/%b expected 00/0/0",
                               log_data[base], log_fe[base], log_pe[base]);
         end
         n_assert++;
         if (log_data[base+1] !== 8'hFF || log_fe[base+1] !== 1'b0 || log_pe[base+1] !== 1'b0) begin
            n_fail++; $display("FAIL b2b_second: got %h/%b/%b expected ff/0/0",
                               log_data[base+1], log_fe[base+1], log_pe[base+1]);
         end
      end
   endtask

   task automatic test_reset_abort;
      int base;
      logic [7:0] d;
      base = log_data.size();
      d = 8'h5A;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(d[i]);
      @(negedge clk);
      serial_in = d[4];
      repeat (20) @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      n_assert++;
      if (bus.o_busy !== 1'b0 || bus.o_data !== 8'h00) begin
         n_fail++; $display("FAIL abort_reset: got busy %b data %h expected 0/00", bus.o_busy, bus.o_data);
      end
      @(negedge clk);
      reset = 1'b0;
      serial_in = 1'b1;
      repeat (BitClk) @(negedge clk);
      send_frame(8'h81, ^8'h81, 1'b1);
      repeat (8) @(negedge clk);
      n_assert++;
      if (log_data.size() !== base + 1) begin
         n_fail++; $display("FAIL abort_count: got %0d pulses expected 1", log_data.size() - base);
      end else begin
         n_assert++;
         if (log_data[base] !== 8'h81) begin
            n_fail++; $display("FAIL abort_data: got %h expected 81", log_data[base]);
         end
      end
   endtask

   task automatic test_idle_flags;
      n_assert++;
      if (stray !== 0) begin
         n_fail++; $display("FAIL idle_flags: got %0d error strobes without valid expected 0", stray);
      end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_frame();
      test_frame_err();
`ifdef RX_UART_PARITY_EN
      test_parity();
`endif
      test_back_to_back();
      test_reset_abort();
      test_idle_flags();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
